ivl_uvm_ovl_always_mc: RTL
==========================

Name: ivl_uvm_ovl_always_mc

Overview:
Multi-channel, parametrised successor to the single-expression ovl_always checker used in the ivl_uvm OVL test suite. It checks NUM_CH boolean expressions in parallel on one clock. Each channel has its own enable, an optional consecutive-failure tolerance, a per-channel violation counter and a sticky flag. It also captures the first failing channel, so UVM scoreboards and directed tests read checker status from signals instead of parsing log output.

Parameters:
NUM_CH, 4, number of independent checked expressions (1..32)
CNT_W, 8, width of each per-channel violation counter
TOLERANCE, 0, consecutive false samples allowed before a fire; 0 gives classic ovl_always behaviour
IDX_W, $clog2(NUM_CH) (minimum 1), width of first_fail_ch

Ports:
clock  input  1  sampling clock; all checks on posedge
reset  input  1  asynchronous, active-high reset
enable  input  NUM_CH  per-channel check enable
test_expr  input  NUM_CH  per-channel expression; 1 = pass
clr  input  1  synchronous clear of counters, sticky flags, first-fail capture
fire  output  NUM_CH  one-cycle registered violation pulse per channel
fire_sticky  output  NUM_CH  set on a channel's first fire; held until clr or reset
any_fire  output  1  OR of fire
viol_cnt  output  NUM_CH*CNT_W  per-channel violation count; channel i occupies bits [i*CNT_W +: CNT_W]
first_fail_vld  output  1  a first failure has been captured
first_fail_ch  output  IDX_W  index of the first failing channel

Behaviour:
- reset high, asynchronous: all outputs go to 0 immediately. This covers fire, fire_sticky, any_fire, viol_cnt, first_fail_vld and first_fail_ch. Internal streak counters also clear. Reset asserted mid-streak discards the streak.
- Per channel, per posedge with reset low:
  - enable[i]=0: streak[i] clears to 0; fire[i]=0; viol_cnt[i] and fire_sticky[i] hold.
  - enable[i]=1, test_expr[i]=1: streak[i] clears to 0; fire[i]=0.
  - enable[i]=1, test_expr[i]=0, X or Z: the sample counts as false. If streak[i]==TOLERANCE, fire[i]=1 on this edge and streak[i] clears to 0. Otherwise streak[i] increments and fire[i]=0.
- Consequence: with TOLERANCE=T and test_expr held false, fire pulses on the (T+1)th false edge, then every T+1 edges after that.
- streak width is $clog2(TOLERANCE+1), minimum 1 bit.
- Latency: fire is registered and visible for exactly one cycle after the sampling edge. There is no combinational path from test_expr to any output.
- viol_cnt[i] increments by 1 on each fire[i] and saturates at 2^CNT_W-1; it never wraps.
- fire_sticky[i] is set on the same edge as fire[i].
- any_fire is registered and aligned with fire.
- First-fail capture:
  - When first_fail_vld=0 and any channel fires, first_fail_vld goes to 1 and first_fail_ch takes the lowest-indexed firing channel.
  - Both hold until clr or reset, even if other channels fire later.
- clr=1 at a posedge:
  - viol_cnt, fire_sticky, first_fail_vld, first_fail_ch and all streaks clear to 0.
  - fire is forced to 0 on that edge.
  - clr overrides any simultaneous violation; nothing is counted or captured on that edge.
- The enable input is sampled every cycle. Toggling enable mid-streak restarts the tolerance window.

Optional Feature:
Macro IVL_UVM_OVL_MSG_EN.
- Defined: on each fire[i], the block prints an $error line with $time, %m, the channel index and the post-increment viol_cnt value. It also prints a $display summary of all non-zero counters at final.
- Undefined: no simulation messages are generated. Signal behaviour is identical in both builds.

Test Plan:
- Reset held 5 clocks with test_expr=4'b0000 and enable=4'hF -> fire=0, all viol_cnt=0, first_fail_vld=0.
- NUM_CH=4, TOLERANCE=0, enable=4'hF, test_expr=4'hF for 10 clocks, then ch2 driven false for 3 clocks -> fire[2] pulses on 3 consecutive edges; viol_cnt[2]=3; first_fail_ch=2; fire_sticky=4'b0100.
- TOLERANCE=2, ch0 false for 7 consecutive clocks -> fire[0] on the 3rd and 6th edges only; viol_cnt[0]=2.
- ch1 and ch3 go false on the same edge from a clean state -> first_fail_ch=1; fire=4'b1010; any_fire=1 for one cycle.
- CNT_W=2, ch0 held false for 6 clocks (TOLERANCE=0) -> viol_cnt[0] saturates at 3. Then clr=1 for one clock while ch0 is still false -> all counters and sticky flags 0, fire=0 on the clr edge, and the next false edge gives viol_cnt[0]=1.
- enable[0]=0 with test_expr[0]=1'bx for 4 clocks -> no fire. Setting enable[0]=1 with test_expr[0] still X -> fire[0]=1 on the next edge. Asserting reset mid-pulse -> fire clears asynchronously.

Source files
------------

// File: rtl/ivl_uvm_ovl_always_mc.sv
// ============================================================================
// Module   : ivl_uvm_ovl_always_mc
// Brief    : Multi-channel "always" checker with consecutive-failure tolerance,
//            saturating violation counters, sticky flags and first-fail capture.
//            Optional macro IVL_UVM_OVL_MSG_EN enables simulation messages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ivl_uvm_ovl_always_mc #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int TOLERANCE = 0,
    parameter int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       test_expr,
    input  logic                    clr,
    output logic [NUM_CH-1:0]       fire,
    output logic [NUM_CH-1:0]       fire_sticky,
    output logic                    any_fire,
    output logic [NUM_CH*CNT_W-1:0] viol_cnt,
    output logic                    first_fail_vld,
    output logic [IDX_W-1:0]        first_fail_ch
);

    localparam int                     c_STREAK_W = (TOLERANCE > 0) ? $clog2(TOLERANCE + 1) : 1;
    localparam logic [c_STREAK_W-1:0]  c_TOL      = c_STREAK_W'(TOLERANCE);
    localparam logic [c_STREAK_W-1:0]  c_ONE      = c_STREAK_W'(1);
    localparam logic [CNT_W-1:0]       c_CNT_MAX  = '1;

    logic [c_STREAK_W-1:0] r_streak [NUM_CH];
    logic [CNT_W-1:0]      r_cnt    [NUM_CH];
    logic [NUM_CH-1:0]     r_fire;
    logic [NUM_CH-1:0]     r_sticky;
    logic                  r_any;
    logic                  r_ff_vld;
    logic [IDX_W-1:0]      r_ff_ch;

    logic [c_STREAK_W-1:0] w_streak_nxt [NUM_CH];
    logic [NUM_CH-1:0]     w_fire_nxt;
    logic [IDX_W-1:0]      w_first_idx;

    // An X/Z expression falls through to the false branch, matching the
    // "anything but 1 is a failure" semantics of ovl_always.
    always_comb begin
        w_fire_nxt  = '0;
        w_first_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_streak_nxt[i] = '0;
            if (!enable[i]) begin
                w_streak_nxt[i] = '0;
            end else if (test_expr[i]) begin
                w_streak_nxt[i] = '0;
            end else if (r_streak[i] == c_TOL) begin
                w_fire_nxt[i] = 1'b1;
            end else begin
                w_streak_nxt[i] = r_streak[i] + c_ONE;
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_fire_nxt[i]) begin
                w_first_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fire   <= '0;
            r_sticky <= '0;
            r_any    <= 1'b0;
            r_ff_vld <= 1'b0;
            r_ff_ch  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_streak[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else if (clr) begin
            r_fire   <= '0;
            r_sticky <= '0;
            r_any    <= 1'b0;
            r_ff_vld <= 1'b0;
            r_ff_ch  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_streak[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            r_fire   <= w_fire_nxt;
            r_any    <= |w_fire_nxt;
            r_sticky <= r_sticky | w_fire_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                r_streak[i] <= w_streak_nxt[i];
                if (w_fire_nxt[i] && (r_cnt[i] != c_CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            if (!r_ff_vld && (|w_fire_nxt)) begin
                r_ff_vld <= 1'b1;
                r_ff_ch  <= w_first_idx;
            end
        end
    end

    assign fire           = r_fire;
    assign fire_sticky    = r_sticky;
    assign any_fire       = r_any;
    assign first_fail_vld = r_ff_vld;
    assign first_fail_ch  = r_ff_ch;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
            assign viol_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    endgenerate

`ifdef IVL_UVM_OVL_MSG_EN
    // Reported one edge after the pulse so the counter already holds its
    // post-increment value.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_fire[i]) begin
                    $error("%0t %m: channel %0d violation, viol_cnt=%0d", $time, i, r_cnt[i]);
                end
            end
        end
    end

    final begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cnt[i] != '0) begin
                $display("%m: channel %0d total violations %0d", i, r_cnt[i]);
            end
        end
    end
`endif

endmodule

`default_nettype wire
